fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage with an integrated IF/ID pipeline register for the 32-bit RISC-V core. It owns the PC and issues single-outstanding requests to instruction memory. It buffers returned instructions through stalls and flushes on branch redirect. It presents `id_instr`/`id_pc`/`id_valid` to decode; `id_instr[6:0]` drives the control unit's `opcode` input directly.

## Interface
- RESET_PC, 32'h0000_0000, address of first fetch after reset
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, always word-aligned
- imem_ready  in  1  memory accepts request when imem_req & imem_ready
- imem_rvalid  in  1  read data valid, exactly one per accepted request, in order, ≥1 cycle after acceptance
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  branch/jump resolved taken; flush and refetch
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- id_stall  in  1  decode cannot accept; hold IF/ID contents
- id_valid  out  1  IF/ID holds a valid instruction
- id_instr  out  32  instruction word to decode
- id_pc  out  32  address of id_instr

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_pc`: address of the outstanding request.
  - State: FETCH / WAIT / DRAIN.
  - One-entry skid buffer: `skid_valid`, `skid_instr`, `skid_pc`.
  - IF/ID output registers.
- `imem_req` = (state==FETCH) & !skid_valid & !redirect_valid.
- `imem_addr` = `pc`.
- FETCH:
  - On req & imem_ready: `req_pc`<=`pc`, `pc`<=`pc`+4 (mod 2^32, wraps 0xFFFF_FFFC→0), go to WAIT.
  - On redirect_valid: `pc`<=redirect_pc & ~3, stay in FETCH.
- WAIT:
  - On imem_rvalid & !redirect_valid: the response goes to IF/ID if (!id_valid | !id_stall), else to skid; go to FETCH.
  - On redirect_valid & !imem_rvalid: go to DRAIN.
  - On redirect_valid & imem_rvalid in the same cycle: discard the response, go to FETCH.
  - Any redirect: `pc`<=redirect_pc & ~3.
- DRAIN:
  - On imem_rvalid: discard the response, go to FETCH.
  - On redirect_valid: update `pc`, remain in DRAIN unless imem_rvalid is also high.
- IF/ID update when (!id_valid | !id_stall):
  - Source priority is skid, then current response, else id_valid<=0.
  - On the cycle skid unloads, it clears.
- Skid loads only when a response arrives while id_valid & id_stall. The skid is never overwritten, because the request gate blocks issue while it is full.
- Redirect (any state) overrides stall:
  - id_valid<=0 and skid_valid<=0 at the next edge.
  - No instruction fetched before the redirect ever reaches id_valid afterward.
- Ordering: instructions leave in program order; no duplicates, no drops except on flush.

## Timing
- Reset values (async on rst_n low):
  - pc=RESET_PC, state=FETCH, skid_valid=0, id_valid=0.
  - id_instr=32'h0000_0013 (NOP), id_pc=0.
  - imem_req is 0 while rst_n=0 and asserts in the first cycle after release.
- Reset mid-operation drops any outstanding request state. The memory is reset by the same rst_n.
- Latency:
  - Request accepted at edge T, rdata returned with rvalid in cycle T+k.
  - id_valid/id_instr visible from cycle T+k+1.
- Throughput: one instruction per k+1 cycles (k=1 → every 2 cycles); one outstanding request maximum.
- A redirect asserted in cycle R means:
  - The first request to the new PC is issued in cycle R+1 (from FETCH), or after the drained rvalid (from WAIT).
  - id_valid=0 from R+1 until the new instruction arrives.
- Stall: id_instr/id_pc/id_valid are stable for every cycle id_stall=1 with no redirect.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants (OPC_RTYPE 7'b0110011, OPC_LOAD 7'b0000011, OPC_STORE 7'b0100011, OPC_BRANCH 7'b1100011).
  - NOP_INSTR 32'h0000_0013.
  - Fetch-state enum (FETCH, WAIT, DRAIN).
- One natural sub-module, `if_id_reg`: IF/ID output register plus skid entry with stall/flush inputs.
- The PC/FSM logic lives in `fetch_unit`.

## Test plan
- Reset release, imem k=1, always ready, no stall:
  - First imem_addr=RESET_PC.
  - id_pc sequence 0x0,0x4,0x8 at cycles 3,5,7.
  - id_instr matches memory.
- imem_ready low 3 cycles:
  - imem_req and imem_addr are held constant.
  - There is no second request.
  - One response is delivered.
- id_stall high 6 cycles during streaming:
  - IF/ID is held.
  - Exactly one instruction is captured in skid.
  - There are no requests while skid is full.
  - After release, the stream continues with no gap-order error and no loss.
- Redirect to 0x100 while in WAIT (k=4):
  - The stale response is discarded.
  - id_valid stays 0 until id_pc=0x100 appears.
- Redirect coincident with imem_rvalid, and with id_stall=1 and skid full:
  - All three are flushed; the next id_pc equals redirect_pc.
  - redirect_pc=0x103 fetches 0x100.
- PC wrap: RESET_PC=0xFFFF_FFFC gives imem_addr 0xFFFF_FFFC then 0x0.
- Async rst_n pulse mid-WAIT: outputs return to reset values immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 core: opcodes, the canonical NOP and the fetch FSM states.
package riscv_pkg;

    localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid that absorbs the single response
// that can land while decode is stalled; a flush empties both entries.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_instr_i,
    input  logic [31:0] rsp_pc_i,
    output logic        skid_valid_o,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o
);

    logic        id_valid_q,   id_valid_d;
    logic [31:0] id_instr_q,   id_instr_d;
    logic [31:0] id_pc_q,      id_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q,    skid_pc_d;

    always_comb begin
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            id_valid_d   = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!id_valid_q || !stall_i) begin
            // The skid always holds the older instruction, so it drains first.
            if (skid_valid_q) begin
                id_valid_d   = 1'b1;
                id_instr_d   = skid_instr_q;
                id_pc_d      = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (rsp_valid_i) begin
                id_valid_d   = 1'b1;
                id_instr_d   = rsp_instr_i;
                id_pc_d      = rsp_pc_i;
            end else begin
                id_valid_d   = 1'b0;
            end
        end else if (rsp_valid_i) begin
            skid_valid_d = 1'b1;
            skid_instr_d = rsp_instr_i;
            skid_pc_d    = rsp_pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= 32'h0;
            skid_valid_q <= 1'b0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign skid_valid_o = skid_valid_q;
    assign id_valid_o   = id_valid_q;
    assign id_instr_o   = id_instr_q;
    assign id_pc_o      = id_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to instruction
// memory and hands responses to decode through the IF/ID register.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         skid_valid;
    logic         rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    pc_d = align_word(redirect_pc);
                end else if (imem_req && imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // A response coincident with a redirect is stale and simply dropped.
                if (redirect_valid) begin
                    pc_d    = align_word(redirect_pc);
                    state_d = imem_rvalid ? FETCH : DRAIN;
                end else if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) pc_d = align_word(redirect_pc);
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Issue is blocked while the skid is full, so the skid can never be overwritten.
    always_comb begin
        imem_req  = rst_n && (state_q == FETCH) && !skid_valid && !redirect_valid;
        rsp_valid = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    end

    assign imem_addr = pc_q;

    if_id_reg u_if_id (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .stall_i      (id_stall),
        .rsp_valid_i  (rsp_valid),
        .rsp_instr_i  (imem_rdata),
        .rsp_pc_i     (req_pc_q),
        .skid_valid_o (skid_valid),
        .id_valid_o   (id_valid),
        .id_instr_o   (id_instr),
        .id_pc_o      (id_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory, program-order scoreboard fed by
// the stimulus process, and an independent monitor that checks every decode hand-off.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ready;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_redirect;
    logic [31:0] w_rpc;
    logic        w_stall;
    logic        w_id_valid;
    logic [31:0] w_id_instr;
    logic [31:0] w_id_pc;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(w_redirect), .redirect_pc(w_rpc),
        .id_stall(w_stall), .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc(w_id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    int          checks;
    int          failures;
    int          cyc;
    int          kfix;
    bit          krand;
    int          ready_mode;
    logic        drv_stall;
    logic        drv_redirect;
    logic [31:0] drv_rpc;
    bit          acc_this;
    bit          w_acc_prev;
    int          rst_epoch;
    int          consumed;

    // Memory contents: a bijective scramble of the address, so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F13;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        exp_next = start;
    endtask

    task automatic sb_fill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then record what the coming
    // rising edge will do (acceptance, redirect) in the memory model and scoreboard.
    task automatic step();
        int k;
        @(negedge clk);
        cyc++;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_rpc;
        id_stall       = drv_stall;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q[0].addr);
            pend_q.delete(0);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        case (ready_mode)
            0:       imem_ready = 1'b1;
            1:       imem_ready = ($urandom_range(0, 3) != 0);
            default: imem_ready = 1'b0;
        endcase
        w_rvalid = w_acc_prev;
        w_rdata  = NOP_INSTR;
        #1;
        acc_this = imem_req && imem_ready;
        if (acc_this) begin
            check("single_outstanding", pend_q.size(), 0);
            k = krand ? int'($urandom_range(1, 3)) : kfix;
            pend_q.push_back('{imem_addr, cyc + k});
        end
        w_acc_prev = w_req && w_ready;
        if (redirect_valid) sb_restart(redirect_pc & ~32'h3);
        sb_fill();
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        pend_q.delete();
        w_acc_prev = 1'b0;
        sb_restart(32'h0000_0000);
        rst_epoch++;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_valid(input int max, input string name);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            found = id_valid;
        end
        check(name, found, 1);
    endtask

    task automatic wait_acc(input int max, input string name);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            found = acc_this;
        end
        check(name, found, 1);
    endtask

    task automatic wait_req(input int max, input string name);
        bit found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            found = imem_req;
        end
        check(name, found, 1);
    endtask

    // Monitor: pops the next program-order address whenever decode takes an instruction.
    int          mon_epoch;
    bit          prev_hold;
    logic        prev_valid;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;
    bit          prev_reqw;
    logic [31:0] prev_addr;

    always @(negedge clk) begin
        logic [31:0] exp_pc;
        #2;
        if (!rst_n || mon_epoch != rst_epoch) begin
            prev_hold = 1'b0;
            prev_reqw = 1'b0;
            mon_epoch = rst_epoch;
        end
        if (rst_n) begin
            if (prev_hold) begin
                check("stall_hold_valid", id_valid, prev_valid);
                check("stall_hold_instr", id_instr, prev_instr);
                check("stall_hold_pc", id_pc, prev_pc);
            end
            if (prev_reqw && !redirect_valid)
                check("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
            if (imem_req) check("addr_align", imem_addr[1:0], 0);
            if (id_valid && !id_stall && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", exp_q.size(), 1);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("id_pc_order", id_pc, exp_pc);
                    check("id_instr_data", id_instr, mem_word(exp_pc));
                    consumed++;
                end
            end
            prev_hold  = id_valid && id_stall && !redirect_valid;
            prev_valid = id_valid;
            prev_instr = id_instr;
            prev_pc    = id_pc;
            prev_reqw  = imem_req && !imem_ready;
            prev_addr  = imem_addr;
        end
    end

    initial begin
        logic [31:0] a0;
        checks = 0; failures = 0; cyc = 0; rst_epoch = 0; mon_epoch = 0; consumed = 0;
        kfix = 1; krand = 1'b0; ready_mode = 0;
        drv_stall = 1'b0; drv_redirect = 1'b0; drv_rpc = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_stall = 1'b0;
        w_ready = 1'b1; w_rvalid = 1'b0; w_rdata = NOP_INSTR;
        w_redirect = 1'b0; w_rpc = 32'h0; w_stall = 1'b0;
        acc_this = 1'b0; w_acc_prev = 1'b0;

        reset_assert();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_id_pc", id_pc, 0);
        check("rst_wrap_req", w_req, 0);
        reset_release();

        // Streaming from reset with single-cycle memory.
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 1) begin
                check("first_req", {imem_req, imem_addr}, {1'b1, 32'h0});
                check("wrap_first", {w_req, w_addr}, {1'b1, 32'hFFFF_FFFC});
            end
            if (c >= 3 && (c % 2) == 1) begin
                check("stream_valid", id_valid, 1);
                check("stream_pc", id_pc, 32'((c - 3) * 2));
                check("stream_instr", id_instr, mem_word(32'((c - 3) * 2)));
            end else begin
                check("stream_gap", id_valid, 0);
            end
            if (c == 3) begin
                check("wrap_addr", {w_req, w_addr}, {1'b1, 32'h0});
                check("wrap_id_pc", {w_id_valid, w_id_pc}, {1'b1, 32'hFFFF_FFFC});
            end
        end

        // Memory not ready: request held, then accepted once.
        ready_mode = 2;
        wait_req(20, "ready_low_req");
        a0 = imem_addr;
        repeat (2) begin
            step();
            check("ready_low_hold", {imem_req, imem_addr}, {1'b1, a0});
        end
        ready_mode = 0;
        step();
        check("ready_accept", {acc_this, imem_addr}, {1'b1, a0});
        repeat (6) step();

        // Decode stall: one response lands in the skid, then issue stops.
        drv_stall = 1'b1;
        wait_valid(20, "stall_fill");
        for (int j = 1; j <= 5; j++) begin
            step();
            check("stall_no_req", imem_req, 0);
        end
        drv_stall = 1'b0;
        repeat (12) step();

        // Redirect while waiting on a slow memory.
        kfix = 4;
        wait_acc(20, "redir_wait_acc");
        drv_redirect = 1'b1; drv_rpc = 32'h0000_0100;
        step();
        drv_redirect = 1'b0;
        wait_valid(40, "redir_wait_new");
        check("redir_wait_pc", {id_valid, id_pc}, {1'b1, 32'h100});
        kfix = 1;
        repeat (10) step();

        // Redirect on the same cycle as a response, with decode stalled.
        drv_stall = 1'b1;
        wait_valid(20, "coincide_fill");
        drv_redirect = 1'b1; drv_rpc = 32'h0000_0103;
        step();
        check("coincide_rvalid", imem_rvalid, 1);
        drv_redirect = 1'b0; drv_stall = 1'b0;
        wait_valid(20, "coincide_new");
        check("coincide_pc", {id_valid, id_pc}, {1'b1, 32'h100});
        repeat (6) step();

        // Redirect while both IF/ID and the skid are full.
        drv_stall = 1'b1;
        wait_valid(20, "skidfull_fill");
        repeat (3) step();
        drv_redirect = 1'b1; drv_rpc = 32'h0000_0203;
        step();
        drv_redirect = 1'b0; drv_stall = 1'b0;
        wait_valid(20, "skidfull_new");
        check("skidfull_pc", {id_valid, id_pc}, {1'b1, 32'h200});
        check("skidfull_instr", id_instr, mem_word(32'h200));
        repeat (6) step();

        // Asynchronous reset while a request is outstanding.
        kfix = 4; drv_stall = 1'b1;
        wait_valid(20, "prerst_fill");
        step();
        check("prerst_valid", id_valid, 1);
        #2;
        reset_assert();
        #1;
        check("midrst_req", imem_req, 0);
        check("midrst_valid", id_valid, 0);
        check("midrst_instr", id_instr, 32'h0000_0013);
        check("midrst_pc", id_pc, 0);
        drv_stall = 1'b0; kfix = 1;
        reset_release();
        step();
        check("postrst_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        repeat (6) step();

        // Randomised traffic.
        krand = 1'b1; ready_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            drv_stall    = ($urandom_range(0, 9) < 3);
            drv_redirect = ($urandom_range(0, 39) == 0);
            drv_rpc      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                      : ($urandom() & 32'h0000_0FFF);
            step();
        end
        krand = 1'b0; ready_mode = 0; drv_stall = 1'b0; drv_redirect = 1'b0;
        repeat (20) step();
        check("progress", (consumed > 200), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
